// File: rtl/mult6u_dot_acc.sv
// mult6u_dot_acc: handshaked dot-product accumulator for 12-bit Mult_6_6 products.
// Sums LEN consecutive accepted products into an ACC_W-bit result with a sticky
// overflow flag and presents it on a valid/ready port.
// Optional build macro MULT6U_DOT_ACC_SAT_EN: clamp the accumulator on overflow
// instead of wrapping it.
module mult6u_dot_acc #(
  parameter int unsigned LEN   = 16,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LEN - 1);

  typedef logic [ACC_W:0]   wide_t;
  typedef logic [ACC_W-1:0] acc_t;

  typedef enum logic {
    StAcc,
    StHold
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic             accept;
  logic             rel;
  logic             last;
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] prod_ext;
  logic             ovf_next;

  // Handshake events; in_ready depends only on state, out_ready and reset.
  always_comb begin
    in_ready = ~rst & ((state_q == StAcc) | out_ready);
    accept   = in_valid & in_ready;
    rel      = out_valid & out_ready;
    last     = (cnt_q == LastCnt);
  end

  // One-bit-wider add; the carry out is the overflow indication.
  always_comb begin
    prod_ext = acc_t'(in_prod);
    sum_full = {1'b0, acc_q} + wide_t'(in_prod);
    ovf_next = ovf_q | sum_full[ACC_W];
`ifdef MULT6U_DOT_ACC_SAT_EN
    // Once clamped, any further nonzero add carries again and stays clamped.
    acc_next = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    acc_next = sum_full[ACC_W-1:0];
`endif
  end

  // ACC/HOLD state machine with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_q)
        StAcc: begin
          if (accept) begin
            if (last) begin
              out_sum   <= acc_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
              state_q   <= StHold;
              acc_q     <= '0;
              cnt_q     <= '0;
              ovf_q     <= 1'b0;
            end else begin
              acc_q <= acc_next;
              cnt_q <= cnt_q + CNT_W'(1);
              ovf_q <= ovf_next;
            end
          end
        end
        StHold: begin
          // An accept here implies out_ready, hence a release in the same cycle.
          if (accept) begin
            if (LEN == 1) begin
              out_sum <= prod_ext;
              out_ovf <= 1'b0;
            end else begin
              acc_q     <= prod_ext;
              cnt_q     <= CNT_W'(1);
              ovf_q     <= 1'b0;
              out_valid <= 1'b0;
              state_q   <= StAcc;
            end
          end else if (rel) begin
            out_valid <= 1'b0;
            state_q   <= StAcc;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_mult6u_dot_acc.sv
// Bench for mult6u_dot_acc: four instances with different LEN/ACC_W, directed
// scenarios followed by random traffic, against a frame-level reference model.
module tb_mult6u_dot_acc;

  localparam int N = 4;
  localparam int unsigned LENS [N] = '{4, 2, 1, 3};
  localparam int unsigned WIDS [N] = '{20, 12, 20, 20};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [N];
  logic        ir   [N];
  logic [11:0] ip   [N];
  logic        ov   [N];
  logic        orr  [N];
  logic [31:0] osum [N];
  logic        oo   [N];

  int errors = 0;
  int checks = 0;

  // Reference model: products of the open frame, pending result.
  longint      fsum [N];
  int          fcnt [N];
  bit          pend [N];
  logic [31:0] esum [N];
  bit          eovf [N];
  bit          acc_m[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 1 : 3;
    localparam int unsigned W = (g == 1) ? 12 : 20;
    logic [W-1:0] s;
    mult6u_dot_acc #(.LEN(L), .ACC_W(W)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .in_prod  (ip[g]),
      .out_valid(ov[g]),
      .out_ready(orr[g]),
      .out_sum  (s),
      .out_ovf  (oo[g])
    );
    assign osum[g] = 32'(s);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      fsum[i] = 0;
      fcnt[i] = 0;
      pend[i] = 1'b0;
      acc_m[i] = 1'b0;
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      iv[i]  = 1'b0;
      ip[i]  = 12'd0;
      orr[i] = 1'b1;
    end
  endtask

  task automatic drive(input int i, input bit v, input int p, input bit r);
    iv[i]  = v;
    ip[i]  = 12'(p);
    orr[i] = r;
  endtask

  // Finished frame: true sum, then wrapped or clamped to the result width.
  task automatic close_frame(input int i);
    longint lim;
    lim = longint'(1) << WIDS[i];
`ifdef MULT6U_DOT_ACC_SAT_EN
    esum[i] = (fsum[i] >= lim) ? 32'(lim - 1) : 32'(fsum[i]);
`else
    esum[i] = 32'(fsum[i] % lim);
`endif
    eovf[i] = (fsum[i] >= lim);
    pend[i] = 1'b1;
    fsum[i] = 0;
    fcnt[i] = 0;
  endtask

  // One clock cycle with the inputs currently driven.
  task automatic step();
    bit r[N];
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(!pend[i] || orr[i]));
      acc_m[i] = iv[i] && (!pend[i] || orr[i]);
      r[i]     = pend[i] && orr[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (r[i]) pend[i] = 1'b0;
      if (acc_m[i]) begin
        fsum[i] += longint'(ip[i]);
        fcnt[i]++;
        if (fcnt[i] == int'(LENS[i])) close_frame(i);
      end
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(pend[i]));
      if (pend[i]) begin
        chk($sformatf("out_sum[%0d]", i), osum[i], esum[i]);
        chk($sformatf("out_ovf[%0d]", i), 32'(oo[i]), 32'(eovf[i]));
      end
    end
  endtask

  initial begin
    idle_all();
    model_reset();
    #12;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd0);
      chk($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst_out_sum[%0d]", i), osum[i], 32'd0);
      chk($sformatf("rst_out_ovf[%0d]", i), 32'(oo[i]), 32'd0);
    end
    rst = 1'b0;

    // Basic frame: 4 x 3969 back-to-back, result valid for exactly one cycle.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 3969, 1'b1);
      step();
      chk("basic_valid_timing", 32'(ov[0]), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("basic_sum", osum[0], 32'd15876);
    chk("basic_ovf", 32'(oo[0]), 32'd0);
    idle_all();
    step();
    chk("basic_one_cycle", 32'(ov[0]), 32'd0);

    // Overflow at 12 bits.
    for (int k = 0; k < 2; k++) begin
      drive(1, 1'b1, 3969, 1'b1);
      step();
    end
`ifdef MULT6U_DOT_ACC_SAT_EN
    chk("ovf_sum", osum[1], 32'd4095);
`else
    chk("ovf_sum", osum[1], 32'd3842);
`endif
    chk("ovf_flag", 32'(oo[1]), 32'd1);
    idle_all();
    step();

    // Backpressure: 5 stalled cycles with input held valid.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1'b1, k, 1'b1);
      step();
    end
    chk("bp_first_sum", osum[0], 32'd10);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 10, 1'b0);
      step();
      chk("bp_stall_ready", 32'(ir[0]), 32'd0);
      chk("bp_stall_sum", osum[0], 32'd10);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1'b1, 10 * k, 1'b1);
      step();
    end
    chk("bp_second_sum", osum[0], 32'd100);
    chk("bp_second_valid", 32'(ov[0]), 32'd1);
    idle_all();
    step();

    // LEN=1: release and accept together keep out_valid high.
    for (int k = 0; k < 3; k++) begin
      drive(2, 1'b1, 5 + 2 * k, 1'b1);
      step();
      chk("len1_valid", 32'(ov[2]), 32'd1);
      chk("len1_sum", osum[2], 32'(5 + 2 * k));
    end
    idle_all();
    step();
    chk("len1_drop", 32'(ov[2]), 32'd0);

    // Reset mid-frame discards the partial sum.
    drive(0, 1'b1, 100, 1'b1);
    step();
    drive(0, 1'b1, 200, 1'b1);
    step();
    idle_all();
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(ir[0]), 32'd0);
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1, 1'b1);
      step();
      chk("midrst_valid_timing", 32'(ov[0]), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("midrst_sum", osum[0], 32'd4);
    idle_all();
    step();

    // Gappy input on LEN=3.
    drive(3, 1'b1, 7, 1'b1); step();
    drive(3, 1'b0, 0, 1'b1); step();
    drive(3, 1'b1, 8, 1'b1); step();
    drive(3, 1'b0, 0, 1'b1); step();
    drive(3, 1'b0, 0, 1'b1); step();
    chk("gappy_not_yet", 32'(ov[3]), 32'd0);
    drive(3, 1'b1, 9, 1'b1); step();
    chk("gappy_valid", 32'(ov[3]), 32'd1);
    chk("gappy_sum", osum[3], 32'd24);
    idle_all();
    step();

    // Random traffic on all instances, biased toward large products.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        iv[i]  = ($urandom_range(0, 3) != 0);
        ip[i]  = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(3000, 4095))
                                             : 12'($urandom_range(0, 4095));
        orr[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult6u_dot_acc.md
# mult6u_dot_acc

- Handshaked accumulation stage that sits directly downstream of the 6x6 unsigned multiplier (`Mult_6_6`) and consumes its 12-bit products.
- Sums a fixed number of consecutive products into one dot-product result and presents it on a valid/ready output port.
- Lets the approximate and truncated multiplier variants be evaluated on realistic dot-product workloads.
- A wrapped or saturated accumulator overflow is flagged alongside the result.

## Interface
- `LEN`, default 16: products per dot product; legal range 1..1024.
- `ACC_W`, default 20: accumulator/result width; must be >= 12.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  product valid.
- `in_ready`  out  1  stage can accept a product this cycle.
- `in_prod`  in  12  unsigned product, i.e. `Mult_6_6` `Out[11:0]`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_W  dot-product result.
- `out_ovf`  out  1  the accumulation of this result overflowed `ACC_W` bits.

## Operation
- **Accept and release events.**
  - A product is accepted when `in_valid & in_ready`.
  - A result is released when `out_valid & out_ready`.
- **States:** ACC (collecting) and HOLD (result pending). Reset enters ACC with `acc=0`, `cnt=0`, `ovf=0`.
- **ACC state.**
  - `in_ready=1`.
  - Each accept computes `acc + in_prod` at `ACC_W+1` bits, with `in_prod` zero-extended. The low `ACC_W` bits are the new `acc` (see Configuration). Bit `ACC_W` ORs into the sticky `ovf`.
  - `cnt` increments on each accept.
  - On the accept with `cnt==LEN-1`: load `out_sum`/`out_ovf` from the updated acc/ovf, set `out_valid=1`, go to HOLD, and clear `acc`, `cnt`, `ovf` internally.
- **HOLD state.**
  - `in_ready = out_ready`.
  - `out_sum` and `out_ovf` stay stable while `out_valid & ~out_ready`.
  - Release with no simultaneous accept: `out_valid` falls and the state returns to ACC.
  - Release and accept in the same cycle: the product starts the next frame, so `acc=in_prod` and `cnt=1`.
    - If `LEN==1`, the stage instead stays in HOLD, reloads `out_sum=in_prod` and `out_ovf=0`, and keeps `out_valid` high.
- **Idle cycles.** Cycles with `in_valid=0` change nothing.
- **Reset mid-frame.** Asserting `rst` mid-frame discards the partial sum and any pending result. No output is produced for that frame.
- **Counter width.** `cnt` is `$clog2(LEN+1)` bits and never wraps past `LEN-1`.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_sum=0`, `out_ovf=0`.
  - `in_ready=0` while `rst` is high, and 1 from the first cycle after deassertion.
- **Latency:** `out_valid` rises on the edge that accepts the LEN-th product, i.e. one cycle after it is presented.
- **Throughput:** one product per cycle sustained when `out_ready` stays high. There are no bubbles between frames.
- **Combinational paths:** `in_ready` is combinational from `out_ready` and the state only. It has no path from `in_valid` or `in_prod`.
- **Registered outputs:** `out_sum`, `out_ovf` and `out_valid` are registered.

## Configuration
- Macro `MULT6U_DOT_ACC_SAT_EN`.
- **Defined:** an overflowing add clamps `acc` to `2^ACC_W-1`. Later adds in the same frame keep it clamped. `out_ovf` is set.
- **Undefined:** `acc` wraps modulo `2^ACC_W` and `out_ovf` is set.
- In both builds, `out_ovf` is the only indication of overflow, and non-overflowing results are identical.

## Test plan
- **Basic frame:** LEN=4, ACC_W=20, `out_ready=1`, products 3969 x4 back-to-back. Expect `out_sum=15876`, `out_ovf=0`, `out_valid` high one cycle after the 4th accept, for exactly 1 cycle.
- **Overflow:** LEN=2, ACC_W=12, products 3969 and 3969.
  - Without the macro: `out_sum=3842`, `out_ovf=1`.
  - With `MULT6U_DOT_ACC_SAT_EN`: `out_sum=4095`, `out_ovf=1`.
- **Backpressure:** LEN=4, `out_ready=0` for 5 cycles after the result appears, while `in_valid` is held high with products 1,2,3,4,10,20,30,40.
  - `out_sum=10` stays stable and `in_ready=0` throughout the stall.
  - After release, the second result is 100.
- **Simultaneous release and accept:** LEN=1, continuous products 5, 7, 9 with `out_ready=1`. Expect `out_sum` sequence 5, 7, 9 on consecutive cycles, with `out_valid` continuously high.
- **Reset mid-frame:** LEN=4, accept 100 and 200, pulse `rst` asynchronously between edges, then send 1,1,1,1.
  - During reset: `out_valid=0` and `in_ready=0`.
  - After reset: the only result is `out_sum=4`.
- **Gappy input:** LEN=3, products 7, idle, 8, idle, idle, 9. Expect `out_sum=24`, with `out_valid` one cycle after the 9 is accepted.
